uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Serial transmit stage fed by the solution assembler: takes one byte per send strobe and shifts it
//  out on the UART tx pin as a framed async character (start, 8 data LSB-first, optional parity, stop).
//  Drives transmit_busy back to the assembler, which holds the next byte until busy falls.
//  Last stage before the FPGA pin; one clock domain; no buffering beyond the shift register.
// PARAMETERS
//  CLKS_PER_BIT  868  clock cycles per bit period (100 MHz / 115200); legal range >= 2
//  PARITY        0    0 = none, 1 = even, 2 = odd
//  STOP_BITS     1    number of stop bits, 1 or 2
// PORTS
//  clk       in   1  system clock
//  rst_n     in   1  asynchronous, active-low reset
//  send      in   1  byte-valid strobe from assembler; accepted only in IDLE
//  byte_in   in   8  byte to transmit; sampled in the accepting cycle only
//  busy      out  1  registered; high from cycle after acceptance until frame end (-> assembler transmit_busy)
//  tx        out  1  serial line, idle high
//  tx_done   out  1  one-cycle pulse in the cycle busy falls
//  overrun   out  1  one-cycle pulse when send is asserted while busy (byte dropped)
// BEHAVIOUR
//  Reset (async, rst_n=0): tx=1, busy=0, tx_done=0, overrun=0, state=IDLE, counters=0; takes effect
//   immediately even mid-frame; line returns high at once, partial frame is abandoned.
//  States: IDLE -> START -> DATA -> (PARITY if PARITY!=0) -> STOP -> IDLE.
//  IDLE: tx=1. If send=1: latch byte_in into shift reg, compute parity from byte_in, clear baud counter,
//   bit index=0, go START. busy and tx=0 both appear on the next clock edge (latency 1).
//  Each state holds tx for exactly CLKS_PER_BIT cycles; baud counter width $clog2(CLKS_PER_BIT),
//   counts 0..CLKS_PER_BIT-1, wraps to 0 at each bit boundary; restarted at frame acceptance.
//  DATA: tx=shift[0]; at bit boundary shift right; after index 7 leave DATA. Index is 3 bits, no wrap use.
//  PARITY: tx = ^byte (even) or ~^byte (odd).
//  STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles; on last cycle go IDLE, busy=0 and tx_done=1 next edge.
//  Frame length from first start cycle to busy fall = CLKS_PER_BIT*(9 + (PARITY!=0) + STOP_BITS).
//  Back-to-back: send held high is accepted in the first IDLE cycle (busy=0); min 1 idle cycle between
//   frames, tx stays high in it.
//  send while busy=1: ignored, shift reg untouched, overrun pulses 1 cycle per offending cycle.
//  send and busy falling same edge: send seen while state still STOP -> overrun; assembler waits for busy=0.
//  byte_in changes after acceptance have no effect on the frame in flight.
//  All outputs registered; no combinational path from send/byte_in to any output.
// STRUCTURE
//  uart_pkg: typedef enum logic [2:0] {IDLE,START,DATA,PAR,STOP} tx_state_t; localparams PARITY_NONE=0,
//   PARITY_EVEN=1, PARITY_ODD=2; shared with the rx deserializer.
//  One sub-module: baud_tick_gen (counter, clear input, one-cycle tick at CLKS_PER_BIT-1), reused by rx.
//  Elaboration-time check: CLKS_PER_BIT<2, PARITY>2 or STOP_BITS not in {1,2} -> $error.
// TESTING (CLKS_PER_BIT=4 unless noted; bench samples tx mid-bit)
//  1 PARITY=0: send 0x33 one cycle -> busy=1 next edge; tx=0,1,1,0,0,1,1,0,0,1 each 4 cycles; busy high
//    40 cycles; tx_done pulse once; byte decoded 0x33.
//  2 PARITY=1 then PARITY=2: send 0x07 -> parity bit 1 (even) / 0 (odd); frame 44 cycles.
//  3 STOP_BITS=2: send 0xA5 -> tx high 8 cycles after bit 7; busy high 44 cycles; next send accepted
//    first cycle busy=0.
//  4 Overrun: send 0x31, then send 0xFF at cycle 10 -> overrun pulse at cycle 11, frame still decodes 0x31,
//    no second frame.
//  5 Reset mid-frame: assert rst_n=0 during DATA bit 3 -> tx=1, busy=0 without clock edge; after release
//    send 0x0A -> clean 0x0A frame.
//  6 Assembler stream: drive 11 bytes via busy handshake (send held until accepted) -> 11 frames decoded
//    in order, zero overrun pulses, 1 idle cycle between frames.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types, parity modes and parity helper
//   Used by the tx serializer and the rx deserializer.
//   tx_state_t  : serializer frame states
//   PARITY_*    : parity mode encodings for the PARITY parameter
//   parity_bit(): parity bit value for a data byte under a given mode
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} tx_state_t;

    localparam int PARITY_NONE = 0;
    localparam int PARITY_EVEN = 1;
    localparam int PARITY_ODD  = 2;

    // Even parity makes the total count of ones (data + parity) even; odd makes it odd.
    function automatic logic parity_bit(input logic [7:0] i_data, input int i_mode);
        return (i_mode == PARITY_ODD) ? ~^i_data : ^i_data;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: bit-period counter producing a one-cycle tick on the last cycle of each bit
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   i_clear  in  holds the counter at 0 (frame not in progress / frame acceptance)
//   o_tick   out high during count CLKS_PER_BIT-1, the last cycle of a bit period
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    output logic o_tick
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    logic [CW-1:0] r_cnt;

    assign o_tick = (r_cnt == CW'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clear || o_tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: frames one byte per send strobe into start/8 data LSB-first/parity/stop on tx
//   clk         in   system clock
//   rst_n       in   asynchronous active-low reset; abandons any frame, line returns high at once
//   i_send      in   byte-valid strobe, accepted only while idle
//   i_byte_in   in   byte to transmit, sampled in the accepting cycle only
//   o_busy      out  high from the cycle after acceptance until the frame ends
//   o_tx        out  serial line, idle high
//   o_tx_done   out  one-cycle pulse in the cycle busy falls
//   o_overrun   out  one-cycle pulse for each cycle send is asserted while a frame is in flight
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_send,
    input  logic [7:0] i_byte_in,
    output logic       o_busy,
    output logic       o_tx,
    output logic       o_tx_done,
    output logic       o_overrun
);

    if (CLKS_PER_BIT < 2 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_params
        $error("uart_tx_serializer: illegal CLKS_PER_BIT/PARITY/STOP_BITS");
    end

    tx_state_t  r_state, w_state_nxt;
    logic [7:0] r_shift, w_shift_nxt;
    logic [2:0] r_idx, w_idx_nxt;
    logic       r_stop_idx, w_stop_idx_nxt;
    logic       r_par, w_par_nxt;
    logic       r_busy, r_tx, r_done, r_ovr;
    logic       w_tick, w_last_stop, w_tx_nxt;

    // Counter is held at zero while idle, so the first start cycle always begins a fresh bit period.
    baud_tick_gen #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_clear (r_state == IDLE),
        .o_tick  (w_tick)
    );

    assign w_last_stop = (STOP_BITS == 1) || r_stop_idx;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_idx_nxt      = r_idx;
        w_stop_idx_nxt = r_stop_idx;
        w_par_nxt      = r_par;
        case (r_state)
            IDLE: if (i_send) begin
                w_state_nxt    = START;
                w_shift_nxt    = i_byte_in;
                w_par_nxt      = parity_bit(i_byte_in, PARITY);
                w_idx_nxt      = '0;
                w_stop_idx_nxt = 1'b0;
            end
            START: if (w_tick) w_state_nxt = DATA;
            DATA: if (w_tick) begin
                w_shift_nxt = r_shift >> 1;
                w_idx_nxt   = r_idx + 3'd1;
                if (r_idx == 3'd7) w_state_nxt = (PARITY != PARITY_NONE) ? PAR : STOP;
            end
            PAR: if (w_tick) w_state_nxt = STOP;
            STOP: if (w_tick) begin
                w_stop_idx_nxt = 1'b1;
                if (w_last_stop) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // tx is registered from the next-state view so the line changes on the same edge as the state.
    assign w_tx_nxt = (w_state_nxt == START) ? 1'b0 :
                      (w_state_nxt == DATA)  ? w_shift_nxt[0] :
                      (w_state_nxt == PAR)   ? w_par_nxt : 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_idx      <= '0;
            r_stop_idx <= 1'b0;
            r_par      <= 1'b0;
            r_busy     <= 1'b0;
            r_tx       <= 1'b1;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_idx      <= w_idx_nxt;
            r_stop_idx <= w_stop_idx_nxt;
            r_par      <= w_par_nxt;
            r_busy     <= (w_state_nxt != IDLE);
            r_tx       <= w_tx_nxt;
            r_done     <= (r_state == STOP) && (w_state_nxt == IDLE);
            // A send in the final stop cycle still counts as an overrun: the frame is not over yet.
            r_ovr      <= i_send && (r_state != IDLE);
        end
    end

    assign o_busy    = r_busy;
    assign o_tx      = r_tx;
    assign o_tx_done = r_done;
    assign o_overrun = r_ovr;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer: four serializer configurations checked against a frame-level model and a mid-bit decoder
module tb_uart_tx_serializer;

    localparam int C = 4;
    localparam int PAR_OF [4] = '{0, 1, 2, 0};
    localparam int STP_OF [4] = '{1, 1, 1, 2};

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] send = '0;
    logic [7:0] byte_in [4];
    logic [3:0] busy, tx, done, ovr;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        uart_tx_serializer #(.CLKS_PER_BIT(C), .PARITY(PAR_OF[g]), .STOP_BITS(STP_OF[g])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_send    (send[g]),
            .i_byte_in (byte_in[g]),
            .o_busy    (busy[g]),
            .o_tx      (tx[g]),
            .o_tx_done (done[g]),
            .o_overrun (ovr[g])
        );
    end

    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
        end
    endtask

    function automatic int nbits(input int k);
        return 10 + ((PAR_OF[k] != 0) ? 1 : 0) + STP_OF[k] - 1;
    endfunction

    // Frame-level model: a frame is a list of bit values, each held for C cycles after acceptance.
    bit         m_act [4];
    int         m_pos [4];
    bit         m_bits [4][12];
    bit         e_tx [4] = '{1, 1, 1, 1};
    bit         e_busy [4];
    bit         e_done [4];
    bit         e_ovr [4];
    logic [7:0] sent_mem [4][256];
    int         wr [4];
    int         rd [4];

    int         busy_cyc [4];
    int         done_cnt [4];
    int         ovr_cnt [4];
    int         dec_cnt [4];
    logic [7:0] last_dec [4];
    int         last_pat [4];
    bit         d_on [4];
    int         d_t [4];
    int         d_pat [4];

    always @(negedge rst_n) begin
        for (int k = 0; k < 4; k++) begin
            m_act[k]  = 0;
            e_tx[k]   = 1;
            e_busy[k] = 0;
            e_done[k] = 0;
            e_ovr[k]  = 0;
            rd[k]     = wr[k];
            d_on[k]   = 0;
        end
    end

    always @(posedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                e_ovr[k]  = send[k] && m_act[k];
                e_done[k] = 0;
                if (m_act[k]) begin
                    m_pos[k]++;
                    if (m_pos[k] == nbits(k) * C) begin
                        m_act[k]  = 0;
                        e_done[k] = 1;
                    end
                end else if (send[k]) begin
                    m_act[k] = 1;
                    m_pos[k] = 0;
                    for (int i = 0; i < 12; i++) m_bits[k][i] = 1;
                    m_bits[k][0] = 0;
                    for (int i = 0; i < 8; i++) m_bits[k][1 + i] = byte_in[k][i];
                    if (PAR_OF[k] != 0) m_bits[k][9] = (PAR_OF[k] == 2) ^ (^byte_in[k]);
                    sent_mem[k][wr[k] % 256] = byte_in[k];
                    wr[k]++;
                end
                e_busy[k] = m_act[k];
                e_tx[k]   = m_act[k] ? m_bits[k][m_pos[k] / C] : 1'b1;
            end
        end
    end

    task automatic finish_frame(input int k);
        int nb;
        int pat;
        logic [7:0] b;
        nb  = nbits(k);
        pat = d_pat[k];
        for (int i = 0; i < 8; i++) b[i] = pat[nb - 2 - i];
        chk($sformatf("start_bit[%0d]", k), pat[nb - 1], 0);
        chk($sformatf("stop_bits[%0d]", k), pat & ((1 << STP_OF[k]) - 1), (1 << STP_OF[k]) - 1);
        if (PAR_OF[k] != 0)
            chk($sformatf("parity_bit[%0d]", k), pat[STP_OF[k]], (PAR_OF[k] == 2) ? ~^b : ^b);
        if (rd[k] == wr[k]) begin
            chk($sformatf("spurious_frame[%0d]", k), 1, 0);
        end else begin
            chk($sformatf("frame_data[%0d]", k), b, sent_mem[k][rd[k] % 256]);
            rd[k]++;
        end
        last_dec[k] = b;
        last_pat[k] = pat;
        dec_cnt[k]++;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("tx[%0d]", k), tx[k], e_tx[k]);
                chk($sformatf("busy[%0d]", k), busy[k], e_busy[k]);
                chk($sformatf("tx_done[%0d]", k), done[k], e_done[k]);
                chk($sformatf("overrun[%0d]", k), ovr[k], e_ovr[k]);
                busy_cyc[k] += int'(busy[k]);
                done_cnt[k] += int'(done[k]);
                ovr_cnt[k]  += int'(ovr[k]);
                if (!d_on[k]) begin
                    if (!tx[k]) begin
                        d_on[k]  = 1;
                        d_t[k]   = 0;
                        d_pat[k] = 0;
                    end
                end else begin
                    d_t[k]++;
                end
                if (d_on[k] && (d_t[k] % C == C / 2)) d_pat[k] = (d_pat[k] << 1) | int'(tx[k]);
                if (d_on[k] && d_t[k] == nbits(k) * C - 1) begin
                    d_on[k] = 0;
                    finish_frame(k);
                end
            end
        end
    end

    task automatic clr();
        for (int k = 0; k < 4; k++) begin
            busy_cyc[k] = 0;
            done_cnt[k] = 0;
            ovr_cnt[k]  = 0;
            dec_cnt[k]  = 0;
        end
    endtask

    task automatic send1(input int k, input logic [7:0] b);
        @(negedge clk);
        send[k]    = 1'b1;
        byte_in[k] = b;
        @(negedge clk);
        send[k]    = 1'b0;
        byte_in[k] = ~b;
        chk($sformatf("accept_busy[%0d]", k), busy[k], 1);
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        while (busy[k] && n < 400) begin
            @(negedge clk);
            n++;
        end
        #1;
        chk($sformatf("idle_timeout[%0d]", k), busy[k], 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        for (int k = 0; k < 4; k++) byte_in[k] = '0;
        repeat (3) @(negedge clk);
        chk("reset_tx", tx, 4'hF);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ovr", ovr, 0);
        rst_n = 1'b1;

        clr();
        send1(0, 8'h33);
        wait_idle(0);
        chk("t1_busy_cycles", busy_cyc[0], 40);
        chk("t1_done_pulses", done_cnt[0], 1);
        chk("t1_decoded", last_dec[0], 8'h33);
        chk("t1_pattern", last_pat[0], 10'b0110011001);

        clr();
        send1(1, 8'h07);
        wait_idle(1);
        chk("t2_even_busy", busy_cyc[1], 44);
        chk("t2_even_pattern", last_pat[1], 11'b01110000011);
        send1(2, 8'h07);
        wait_idle(2);
        chk("t2_odd_busy", busy_cyc[2], 44);
        chk("t2_odd_pattern", last_pat[2], 11'b01110000001);

        clr();
        send1(3, 8'hA5);
        wait_idle(3);
        chk("t3_busy_cycles", busy_cyc[3], 44);
        chk("t3_pattern", last_pat[3], 11'b01010010111);
        send[3]    = 1'b1;
        byte_in[3] = 8'h5A;
        @(negedge clk);
        chk("t3_first_idle_accept", busy[3], 1);
        send[3] = 1'b0;
        wait_idle(3);
        chk("t3_second_frame", last_dec[3], 8'h5A);
        chk("t3_no_overrun", ovr_cnt[3], 0);

        clr();
        @(negedge clk);
        send[0]    = 1'b1;
        byte_in[0] = 8'h31;
        @(negedge clk);
        send[0]    = 1'b0;
        byte_in[0] = 8'hFF;
        repeat (9) @(negedge clk);
        send[0] = 1'b1;
        @(negedge clk);
        send[0] = 1'b0;
        #1;
        chk("t4_overrun_pulse", ovr[0], 1);
        wait_idle(0);
        chk("t4_overrun_count", ovr_cnt[0], 1);
        chk("t4_decoded", last_dec[0], 8'h31);
        repeat (50) @(negedge clk);
        #1;
        chk("t4_single_frame", dec_cnt[0], 1);
        chk("t4_busy_cycles", busy_cyc[0], 40);

        clr();
        send1(0, 8'hC3);
        repeat (17) @(negedge clk);
        chk("t5_mid_frame_busy", busy[0], 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t5_async_tx", tx[0], 1);
        chk("t5_async_busy", busy[0], 0);
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        send1(0, 8'h0A);
        wait_idle(0);
        chk("t5_frames", dec_cnt[0], 1);
        chk("t5_decoded", last_dec[0], 8'h0A);

        clr();
        wait_idle(0);
        for (int i = 0; i < 11; i++) begin
            b          = 8'($urandom);
            send[0]    = 1'b1;
            byte_in[0] = b;
            @(negedge clk);
            chk("t6_stream_accept", busy[0], 1);
            send[0]    = 1'b0;
            byte_in[0] = ~b;
            wait_idle(0);
        end
        chk("t6_frames", dec_cnt[0], 11);
        chk("t6_done_pulses", done_cnt[0], 11);
        chk("t6_overruns", ovr_cnt[0], 0);

        repeat (3000) begin
            @(negedge clk);
            for (int k = 0; k < 4; k++) begin
                send[k]    = ($urandom_range(0, 15) == 0);
                byte_in[k] = 8'($urandom);
            end
        end
        @(negedge clk);
        send = '0;
        for (int k = 0; k < 4; k++) wait_idle(k);
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("drained[%0d]", k), rd[k], wr[k]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
